// File: rtl/led_code_pkg.sv
// Shared types and helpers for the status-LED blink-code sequencer.
// Contents: the sequencer state enum and a width helper for the phase counter.
package led_code_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2,
        GAP  = 2'd3
    } led_state_t;

    // Bits needed to hold 0..max(on, off, gap) ticks.
    function automatic int phase_width(input int on_t, input int off_t, input int gap_t);
        int m;
        m = on_t;
        if (off_t > m) m = off_t;
        if (gap_t > m) m = gap_t;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/led_blink_code_tick_div.sv
// tick_div: free-running prescaler producing a one-cycle tick every CLK_DIV
// clocks. Shared by the slow-rate LED and debounce logic.
// Ports:
//   clk  - system clock
//   rst  - synchronous active-high reset
//   clr  - synchronous clear; restarts the tick grid from zero
//   tick - high in the cycle where the count sits at CLK_DIV-1
module tick_div #(
    parameter int CLK_DIV = 12_500_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/led_blink_code.sv
// led_blink_code: repeats a status code on one LED as n pulses followed by
// a dark gap. Codes arrive over valid/ready into a one-deep pending slot and
// only take effect at a pattern boundary (IDLE or end of GAP).
// Ports:
//   clk          - system clock
//   rst          - synchronous active-high reset
//   code_in      - status code (pulse count); 0 means LED off
//   code_valid   - code_in is offered
//   code_ready   - pending slot empty (combinational)
//   led          - registered LED drive
//   pattern_done - one-cycle pulse at the end of each GAP
//
// state | meaning
// IDLE  | LED dark, waiting for a nonzero code
// ON    | LED lit for ON_TICKS ticks
// OFF   | LED dark for OFF_TICKS ticks between pulses
// GAP   | LED dark for GAP_TICKS ticks after the last pulse
module led_blink_code
    import led_code_pkg::*;
#(
    parameter int CLK_DIV    = 12_500_000,
    parameter int ON_TICKS   = 2,
    parameter int OFF_TICKS  = 2,
    parameter int GAP_TICKS  = 8,
    parameter int CODE_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [CODE_WIDTH-1:0] code_in,
    input  logic                  code_valid,
    output logic                  code_ready,
    output logic                  led,
    output logic                  pattern_done
);

    localparam int PH_W = phase_width(ON_TICKS, OFF_TICKS, GAP_TICKS);
    localparam logic [PH_W-1:0] ON_LAST  = PH_W'(ON_TICKS - 1);
    localparam logic [PH_W-1:0] OFF_LAST = PH_W'(OFF_TICKS - 1);
    localparam logic [PH_W-1:0] GAP_LAST = PH_W'(GAP_TICKS - 1);
    localparam logic [CODE_WIDTH-1:0] ONE = CODE_WIDTH'(1);

    led_state_t            state, state_nx;
    logic [CODE_WIDTH-1:0] pending, pending_nx;
    logic                  pending_valid, pending_valid_nx;
    logic [CODE_WIDTH-1:0] active_code, active_code_nx;
    logic [CODE_WIDTH-1:0] pulses_left, pulses_left_nx;
    logic [PH_W-1:0]       phase_cnt, phase_cnt_nx;
    logic                  done_nx;
    logic                  tick;
    logic                  tick_clr;

    assign code_ready = !pending_valid && !rst;

    tick_div #(
        .CLK_DIV(CLK_DIV)
    ) u_tick_div (
        .clk (clk),
        .rst (rst),
        .clr (tick_clr),
        .tick(tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            pending       <= '0;
            pending_valid <= 1'b0;
            active_code   <= '0;
            pulses_left   <= '0;
            phase_cnt     <= '0;
            led           <= 1'b0;
            pattern_done  <= 1'b0;
        end else begin
            state         <= state_nx;
            pending       <= pending_nx;
            pending_valid <= pending_valid_nx;
            active_code   <= active_code_nx;
            pulses_left   <= pulses_left_nx;
            phase_cnt     <= phase_cnt_nx;
            led           <= (state_nx == ON);
            pattern_done  <= done_nx;
        end
    end

    always_comb begin
        state_nx         = state;
        pending_nx       = pending;
        pending_valid_nx = pending_valid;
        active_code_nx   = active_code;
        pulses_left_nx   = pulses_left;
        phase_cnt_nx     = phase_cnt;
        done_nx          = 1'b0;
        tick_clr         = 1'b0;

        // Accept and consume never coincide: accept needs the slot empty,
        // consume needs it full.
        if (code_valid && code_ready) begin
            pending_nx       = code_in;
            pending_valid_nx = 1'b1;
        end

        unique case (state)
            IDLE: begin
                if (pending_valid) begin
                    pending_valid_nx = 1'b0;
                    active_code_nx   = pending;
                    if (pending != '0) begin
                        state_nx       = ON;
                        pulses_left_nx = pending;
                        phase_cnt_nx   = '0;
                        tick_clr       = 1'b1;
                    end
                end
            end
            ON: begin
                if (tick) begin
                    if (phase_cnt == ON_LAST) begin
                        state_nx     = OFF;
                        phase_cnt_nx = '0;
                    end else begin
                        phase_cnt_nx = phase_cnt + 1'b1;
                    end
                end
            end
            OFF: begin
                if (tick) begin
                    if (phase_cnt == OFF_LAST) begin
                        phase_cnt_nx = '0;
                        if (pulses_left == ONE) begin
                            state_nx = GAP;
                        end else begin
                            pulses_left_nx = pulses_left - 1'b1;
                            state_nx       = ON;
                        end
                    end else begin
                        phase_cnt_nx = phase_cnt + 1'b1;
                    end
                end
            end
            GAP: begin
                if (tick) begin
                    if (phase_cnt == GAP_LAST) begin
                        // Prescaler keeps running here so repeats stay on the tick grid.
                        done_nx      = 1'b1;
                        phase_cnt_nx = '0;
                        if (pending_valid) begin
                            pending_valid_nx = 1'b0;
                            active_code_nx   = pending;
                            if (pending == '0) begin
                                state_nx = IDLE;
                            end else begin
                                state_nx       = ON;
                                pulses_left_nx = pending;
                            end
                        end else begin
                            state_nx       = ON;
                            pulses_left_nx = active_code;
                        end
                    end else begin
                        phase_cnt_nx = phase_cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

endmodule
